// File: rtl/traffic_light_ctrl_nway.sv
// N-way intersection light controller: minimum-green / yellow / all-red phase timing,
// round-robin handover driven by traffic sensors, and a parade mode that pins one approach.
module traffic_light_ctrl_nway #(
  parameter int N_WAY       = 4,
  parameter int GREEN_MIN   = 4,
  parameter int YELLOW_CYC  = 2,
  parameter int ALL_RED_CYC = 1,
  parameter int PARADE_IDX  = 1,
  localparam int IDXW       = (N_WAY <= 2) ? 1 : $clog2(N_WAY)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_WAY-1:0]   i_T,
  input  logic               i_P,
  input  logic               i_R,
  output logic [2*N_WAY-1:0] o_L,
  output logic [IDXW-1:0]    o_cur_idx,
  output logic [1:0]         o_phase,
  output logic               o_parade
);

  localparam int CMAX0 = (GREEN_MIN > YELLOW_CYC) ? GREEN_MIN : YELLOW_CYC;
  localparam int CMAX1 = (CMAX0 > ALL_RED_CYC) ? CMAX0 : ALL_RED_CYC;
  localparam int CMAX  = (CMAX1 > 2) ? CMAX1 : 2;
  localparam int CNTW  = $clog2(CMAX);

  localparam logic [CNTW-1:0] G_LAST  = CNTW'(GREEN_MIN - 1);
  localparam logic [CNTW-1:0] Y_LAST  = CNTW'(YELLOW_CYC - 1);
  localparam logic [CNTW-1:0] AR_LAST = CNTW'((ALL_RED_CYC > 0) ? ALL_RED_CYC - 1 : 0);
  localparam logic [IDXW-1:0] PIDX    = IDXW'(PARADE_IDX);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  typedef enum logic {
    M_NORMAL = 1'b0,
    M_PARADE = 1'b1
  } mode_e;

  phase_e          r_phase, w_phase;
  mode_e           r_mode,  w_mode;
  logic [IDXW-1:0] r_cur,   w_cur;
  logic [IDXW-1:0] r_nxt,   w_nxt;
  logic [CNTW-1:0] r_cnt,   w_cnt;

  logic            w_found;
  logic [IDXW-1:0] w_sel;
  logic [IDXW-1:0] w_k;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase <= PH_GREEN;
      r_mode  <= M_NORMAL;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase;
      r_mode  <= w_mode;
      r_cur   <= w_cur;
      r_nxt   <= w_nxt;
      r_cnt   <= w_cnt;
    end
  end

  // First requesting approach after cur, wrapping; cur itself is never a candidate.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_cur;
    w_k     = '0;
    for (int unsigned i = 1; i < N_WAY; i++) begin
      w_k = IDXW'((int'(r_cur) + i) % N_WAY);
      if (!w_found && i_T[w_k]) begin
        w_found = 1'b1;
        w_sel   = w_k;
      end
    end
  end

  always_comb begin
    w_mode = r_mode;
    case (r_mode)
      M_NORMAL: if (i_P) w_mode = M_PARADE;
      M_PARADE: if (i_R) w_mode = M_NORMAL;
      default:  w_mode = M_NORMAL;
    endcase
  end

  always_comb begin
    w_phase = r_phase;
    w_cur   = r_cur;
    w_nxt   = r_nxt;
    w_cnt   = r_cnt;
    case (r_phase)
      PH_GREEN: begin
        if (r_cnt != G_LAST) begin
          w_cnt = r_cnt + 1'b1;
        end else if (r_mode == M_PARADE) begin
          if (r_cur != PIDX) begin
            w_phase = PH_YELLOW;
            w_cnt   = '0;
            w_nxt   = PIDX;
          end
        end else if (!i_T[r_cur] && w_found) begin
          w_phase = PH_YELLOW;
          w_cnt   = '0;
          w_nxt   = w_sel;
        end
      end
      PH_YELLOW: begin
        if (r_cnt == Y_LAST) begin
          w_cnt = '0;
          if (ALL_RED_CYC == 0) begin
            w_phase = PH_GREEN;
            w_cur   = r_nxt;
          end else begin
            w_phase = PH_ALLRED;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (r_cnt == AR_LAST) begin
          w_phase = PH_GREEN;
          w_cur   = r_nxt;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_phase = PH_GREEN;
        w_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    o_L = {N_WAY{2'b10}};
    case (r_phase)
      PH_GREEN:  o_L[{r_cur, 1'b0} +: 2] = 2'b00;
      PH_YELLOW: o_L[{r_cur, 1'b0} +: 2] = 2'b01;
      default:   o_L = {N_WAY{2'b10}};
    endcase
  end

  assign o_cur_idx = r_cur;
  assign o_phase   = r_phase;
  assign o_parade  = (r_mode == M_PARADE);

endmodule

// File: tb/tb_traffic_light_ctrl_nway.sv
// Directed bench for traffic_light_ctrl_nway: vector table for handover/wrap/hold,
// hand sequences for parade, the no-all-red variant, and asynchronous reset.
module tb_traffic_light_ctrl_nway;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] t   = 4'b0000;
  logic       p   = 1'b0;
  logic       r   = 1'b0;

  logic [7:0] l,   l_v;
  logic [1:0] cur, cur_v;
  logic [1:0] ph,  ph_v;
  logic       par, par_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_nway #(
    .N_WAY(4), .GREEN_MIN(4), .YELLOW_CYC(2), .ALL_RED_CYC(1), .PARADE_IDX(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_T(t), .i_P(p), .i_R(r),
    .o_L(l), .o_cur_idx(cur), .o_phase(ph), .o_parade(par)
  );

  traffic_light_ctrl_nway #(
    .N_WAY(4), .GREEN_MIN(4), .YELLOW_CYC(2), .ALL_RED_CYC(0), .PARADE_IDX(1)
  ) dut_v (
    .i_clk(clk), .i_rst(rst), .i_T(t), .i_P(p), .i_R(r),
    .o_L(l_v), .o_cur_idx(cur_v), .o_phase(ph_v), .o_parade(par_v)
  );

  typedef struct {
    logic [3:0]  t;
    logic        p;
    logic        r;
    int unsigned reps;
    logic [7:0]  l;
    logic [1:0]  cur;
    logic [1:0]  ph;
    logic        par;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] vt, input logic vp, input logic vr, input int unsigned reps,
                     input logic [7:0] vl, input logic [1:0] vc, input logic [1:0] vph, input logic vpar);
    vec_t v;
    v.t = vt; v.p = vp; v.r = vr; v.reps = reps;
    v.l = vl; v.cur = vc; v.ph = vph; v.par = vpar;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] el, input logic [1:0] ec,
                           input logic [1:0] eph, input logic epar);
    check({name, "_L"},      32'(l),   32'(el));
    check({name, "_cur"},    32'(cur), 32'(ec));
    check({name, "_phase"},  32'(ph),  32'(eph));
    check({name, "_parade"}, 32'(par), 32'(epar));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    t = 4'b0000; p = 1'b0; r = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while reset is held
    #3;
    check_all("reset", 8'hA8, 2'd0, 2'd0, 1'b0);
    rst = 1'b0;

    // Idle: no traffic, approach 0 stays green
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all($sformatf("idle%0d", i), 8'hA8, 2'd0, 2'd0, 1'b0);
    end

    // Handover, wrap/skip, hold with traffic, no pre-emption, wrap from 3
    add(4'b0100, 0, 0,  3, 8'hA8, 2'd0, 2'd0, 0);
    add(4'b0100, 0, 0,  2, 8'hA9, 2'd0, 2'd1, 0);
    add(4'b0100, 0, 0,  1, 8'hAA, 2'd0, 2'd2, 0);
    add(4'b0100, 0, 0,  1, 8'h8A, 2'd2, 2'd0, 0);
    add(4'b0011, 0, 0,  3, 8'h8A, 2'd2, 2'd0, 0);
    add(4'b0011, 0, 0,  2, 8'h9A, 2'd2, 2'd1, 0);
    add(4'b0011, 0, 0,  1, 8'hAA, 2'd2, 2'd2, 0);
    add(4'b0011, 0, 0,  1, 8'hA8, 2'd0, 2'd0, 0);
    add(4'b1111, 0, 0, 30, 8'hA8, 2'd0, 2'd0, 0);
    add(4'b1110, 0, 0,  2, 8'hA9, 2'd0, 2'd1, 0);
    add(4'b1110, 0, 0,  1, 8'hAA, 2'd0, 2'd2, 0);
    add(4'b1110, 0, 0,  6, 8'hA2, 2'd1, 2'd0, 0);
    add(4'b1100, 0, 0,  2, 8'hA6, 2'd1, 2'd1, 0);
    add(4'b1100, 0, 0,  1, 8'hAA, 2'd1, 2'd2, 0);
    add(4'b1100, 0, 0,  1, 8'h8A, 2'd2, 2'd0, 0);
    add(4'b1000, 0, 0,  3, 8'h8A, 2'd2, 2'd0, 0);
    add(4'b1000, 0, 0,  2, 8'h9A, 2'd2, 2'd1, 0);
    add(4'b1000, 0, 0,  1, 8'hAA, 2'd2, 2'd2, 0);
    add(4'b1000, 0, 0,  1, 8'h2A, 2'd3, 2'd0, 0);
    add(4'b0100, 0, 0,  3, 8'h2A, 2'd3, 2'd0, 0);
    add(4'b0100, 0, 0,  2, 8'h6A, 2'd3, 2'd1, 0);
    add(4'b0100, 0, 0,  1, 8'hAA, 2'd3, 2'd2, 0);
    add(4'b0100, 0, 0,  1, 8'h8A, 2'd2, 2'd0, 0);

    do_reset();
    foreach (tbl[k]) begin
      for (int unsigned j = 0; j < tbl[k].reps; j++) begin
        t = tbl[k].t; p = tbl[k].p; r = tbl[k].r;
        tick();
        check_all($sformatf("vec%0d_%0d", k, j), tbl[k].l, tbl[k].cur, tbl[k].ph, tbl[k].par);
      end
    end

    // Parade: forced exit from 0, hold on 1 despite sensors, release, then P and R together
    do_reset();
    p = 1'b1;
    tick();
    check_all("par_req", 8'hA8, 2'd0, 2'd0, 1'b1);
    p = 1'b0;
    tick(); tick();
    check_all("par_g3", 8'hA8, 2'd0, 2'd0, 1'b1);
    tick();
    check_all("par_forced_y", 8'hA9, 2'd0, 2'd1, 1'b1);
    t = 4'b1101;
    tick();
    check_all("par_y2", 8'hA9, 2'd0, 2'd1, 1'b1);
    tick();
    check_all("par_ar", 8'hAA, 2'd0, 2'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("par_hold%0d", i), 8'hA2, 2'd1, 2'd0, 1'b1);
    end
    r = 1'b1;
    tick();
    check_all("par_rel", 8'hA2, 2'd1, 2'd0, 1'b0);
    r = 1'b0;
    tick();
    check_all("rel_y", 8'hA6, 2'd1, 2'd1, 1'b0);
    tick();
    tick();
    check_all("rel_ar", 8'hAA, 2'd1, 2'd2, 1'b0);
    tick();
    check_all("rel_g2", 8'h8A, 2'd2, 2'd0, 1'b0);
    p = 1'b1; r = 1'b1;
    tick();
    check_all("pr_normal", 8'h8A, 2'd2, 2'd0, 1'b1);
    tick();
    check_all("pr_parade", 8'h8A, 2'd2, 2'd0, 1'b0);
    p = 1'b0; r = 1'b0;
    tick(); tick(); tick();
    check_all("pr_hold", 8'h8A, 2'd2, 2'd0, 1'b0);

    // Variant without all-red: yellow goes straight to green
    do_reset();
    t = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    check("var_y_L", 32'(l_v), 32'h0A9);
    check("var_y_phase", 32'(ph_v), 32'd1);
    tick();
    check("var_y2_L", 32'(l_v), 32'h0A9);
    tick();
    check("var_g_L", 32'(l_v), 32'h08A);
    check("var_g_cur", 32'(cur_v), 32'd2);
    check("var_g_phase", 32'(ph_v), 32'd0);
    check("main_ar_L", 32'(l), 32'h0AA);

    // Asynchronous reset mid-yellow while in parade
    do_reset();
    p = 1'b1;
    tick();
    p = 1'b0;
    tick(); tick(); tick();
    check_all("ar_pre", 8'hA9, 2'd0, 2'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("ar_async", 8'hA8, 2'd0, 2'd0, 1'b0);
    check("ar_async_var_L", 32'(l_v), 32'h0A8);
    rst = 1'b0;
    tick();
    check_all("ar_after", 8'hA8, 2'd0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
